// File: rtl/disp_pkg.sv
// Shared types for the seven-segment display path: digit select, nibble,
// packed four-digit word, and the double-buffered display record.
package disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEL_W      = 2;
  localparam int NIB_W      = 4;

  typedef logic [SEL_W-1:0]            digit_sel_t;
  typedef logic [NIB_W-1:0]            nibble_t;
  typedef logic [NUM_DIGITS*NIB_W-1:0] disp_word_t;
  typedef logic [NUM_DIGITS-1:0]       digit_mask_t;

  typedef struct packed {
    disp_word_t  value;
    digit_mask_t dp;
    digit_mask_t en;
  } disp_buf_t;

  function automatic nibble_t pick_nibble(input disp_word_t w, input digit_sel_t s);
    return w[NIB_W*int'(s) +: NIB_W];
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: emits a one-cycle tick every DIV enabled cycles.
// The count freezes while en is low so a paused slot resumes where it stopped.
module tick_gen #(
  parameter int DIV   = 100000,
  parameter int CNT_W = $clog2(DIV)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = en && (cnt_q == CNT_W'(DIV - 1));
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit seven-segment scan controller: rotates the digit select and
// steers double-buffered display data that only changes on frame boundaries.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  disp_word_t  value,
  input  digit_mask_t dp_mask,
  input  digit_mask_t digit_en,
  output digit_sel_t  an_sel,
  output nibble_t     nibble,
  output logic        dp,
  output logic        blank,
  output logic        frame_tick,
  output logic        pending
);

  logic       tick;
  logic       boundary;
  digit_sel_t sel_q, sel_d;
  disp_buf_t  shadow_q, shadow_d;
  disp_buf_t  active_q, active_d;
  logic       pending_q, pending_d;
  logic       frame_tick_q, frame_tick_d;

  tick_gen #(
    .DIV   (REFRESH_DIV),
    .CNT_W (CNT_W)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (tick)
  );

  // A load on the boundary cycle still promotes the old shadow; the new
  // data waits in the shadow for the following frame.
  always_comb begin
    sel_d        = sel_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    boundary     = tick && (sel_q == SEL_W'(NUM_DIGITS - 1));
    frame_tick_d = boundary;

    if (tick) begin
      sel_d = sel_q + SEL_W'(1);
    end
    if (boundary) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d.value = value;
      shadow_d.dp    = dp_mask;
      shadow_d.en    = digit_en;
      pending_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an_sel     = sel_q;
  assign nibble     = pick_nibble(active_q.value, sel_q);
  assign dp         = active_q.dp[sel_q];
  assign blank      = ~active_q.en[sel_q];
  assign frame_tick = frame_tick_q;
  assign pending    = pending_q;

endmodule
